// File: rtl/snes_controller_poller_pkg.sv
// Shared types and constants for the NES/SNES controller poller and the replay side.
// Holds the FSM state encoding, the legal frame widths and the default protocol timing.
package snes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int NES_BITS   = 8;
  localparam int SNES_BITS  = 16;
  localparam int MOUSE_BITS = 32;
  localparam int WIDE_BITS  = 64;

  // 12 us latch and 6 us serial half period at a 50 MHz system clock
  localparam int DEFAULT_LATCH_CYCLES = 600;
  localparam int DEFAULT_HALF_CYCLES  = 300;

  // The phase counter only counts 0..longest-1, so clog2 of the longest phase is enough
  function automatic int phase_width(input int latch_cycles, input int half_cycles);
    int longest;
    longest = (latch_cycles > half_cycles) ? latch_cycles : half_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/snes_controller_poller_if.sv
// Bundle of the poll request/result signals and the three controller wires.
// master = the poller itself, slave = whoever requests polls and drives the data line.
interface snes_controller_poller_if
  import snes_pkg::*;
#(
  parameter int NUM_BITS = SNES_BITS
);

  logic                start;
  logic                busy;
  logic [NUM_BITS-1:0] frame_out;
  logic                frame_valid;
  logic                latch_out;
  logic                pclk_out;
  logic                data_in;

  modport master (
    input  start,
    input  data_in,
    output busy,
    output frame_out,
    output frame_valid,
    output latch_out,
    output pclk_out
  );

  modport slave (
    output start,
    output data_in,
    input  busy,
    input  frame_out,
    input  frame_valid,
    input  latch_out,
    input  pclk_out
  );

endinterface

// File: rtl/snes_controller_poller_sync_2ff.sv
// Two-flop synchroniser for asynchronous controller lines; reset value is the idle
// line level so a freshly reset block never sees a phantom button press.
module sync_2ff #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          meta_reg[gi] <= RESET_VAL;
          sync_reg[gi] <= RESET_VAL;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/snes_controller_poller.sv
// Console-side NES/SNES poller: latch pulse, NUM_BITS-1 serial clock pulses, and one
// parallel frame per poll with the first bit on the wire landing in frame_out MSB.
module snes_controller_poller
  import snes_pkg::*;
#(
  parameter int NUM_BITS     = SNES_BITS,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  parameter int HALF_CYCLES  = DEFAULT_HALF_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  snes_controller_poller_if.master    bus
);

  localparam int PW = phase_width(LATCH_CYCLES, HALF_CYCLES);
  localparam int BW = $clog2(NUM_BITS) + 1;

  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);

  state_t              state_reg;
  logic [PW-1:0]       phase_reg;
  logic [BW-1:0]       bit_cnt_reg;
  logic [NUM_BITS-1:0] acc_reg;
  logic [NUM_BITS-1:0] frame_reg;
  logic                latch_reg;
  logic                pclk_reg;
  logic                busy_reg;
  logic                valid_reg;

  logic                data_sync;
  logic                half_last;
  logic [NUM_BITS-1:0] acc_shift;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_data_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.data_in),
    .q     (data_sync)
  );

  assign half_last = (phase_reg == HALF_LAST);
  assign acc_shift = (acc_reg << 1) | NUM_BITS'(data_sync);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      bit_cnt_reg <= '0;
      acc_reg     <= '0;
      frame_reg   <= '1;
      latch_reg   <= 1'b0;
      pclk_reg    <= 1'b1;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg   <= LATCH;
            latch_reg   <= 1'b1;
            busy_reg    <= 1'b1;
            phase_reg   <= '0;
            bit_cnt_reg <= '0;
            acc_reg     <= '0;
          end
        end
        LATCH: begin
          if (phase_reg == LATCH_LAST) begin
            state_reg <= SETTLE;
            latch_reg <= 1'b0;
            phase_reg <= '0;
          end else begin
            phase_reg <= phase_reg + PW'(1);
          end
        end
        SETTLE: begin
          // The controller presents bit 0 while latched, so it is sampled before any clock
          if (half_last) begin
            acc_reg     <= acc_shift;
            bit_cnt_reg <= BW'(1);
            phase_reg   <= '0;
            if (NUM_BITS == 1) begin
              state_reg <= DONE;
            end else begin
              state_reg <= LOW;
              pclk_reg  <= 1'b0;
            end
          end else begin
            phase_reg <= phase_reg + PW'(1);
          end
        end
        LOW: begin
          if (half_last) begin
            state_reg <= HIGH;
            pclk_reg  <= 1'b1;
            phase_reg <= '0;
          end else begin
            phase_reg <= phase_reg + PW'(1);
          end
        end
        HIGH: begin
          // Sampling at the end of the high half leaves time for the synchroniser
          if (half_last) begin
            acc_reg     <= acc_shift;
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
            phase_reg   <= '0;
            if (bit_cnt_reg == BIT_LAST) begin
              state_reg <= DONE;
            end else begin
              state_reg <= LOW;
              pclk_reg  <= 1'b0;
            end
          end else begin
            phase_reg <= phase_reg + PW'(1);
          end
        end
        DONE: begin
          frame_reg <= acc_reg;
          valid_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.latch_out   = latch_reg;
  assign bus.pclk_out    = pclk_reg;
  assign bus.busy        = busy_reg;
  assign bus.frame_out   = frame_reg;
  assign bus.frame_valid = valid_reg;

endmodule

// File: tb/tb_snes_controller_poller.sv
// Directed bench: three pollers (8/16/32 bits, latch 4, half period 3) each talking to a
// behavioural controller that reloads on latch and shifts on every serial clock rise.
module tb_snes_controller_poller;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  snes_controller_poller_if #(.NUM_BITS(8))  bus8();
  snes_controller_poller_if #(.NUM_BITS(16)) bus16();
  snes_controller_poller_if #(.NUM_BITS(32)) bus32();

  snes_controller_poller #(.NUM_BITS(8), .LATCH_CYCLES(4), .HALF_CYCLES(3)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .bus (bus8)
  );
  snes_controller_poller #(.NUM_BITS(16), .LATCH_CYCLES(4), .HALF_CYCLES(3)) u_dut16 (
    .clk (clk), .rst_n (rst_n), .bus (bus16)
  );
  snes_controller_poller #(.NUM_BITS(32), .LATCH_CYCLES(4), .HALF_CYCLES(3)) u_dut32 (
    .clk (clk), .rst_n (rst_n), .bus (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller models: parallel load on latch, shift left (fill 1) on pclk rise
  logic [7:0]  pat8  = 8'hFF;
  logic [31:0] pat32 = 32'hFFFF_FFFF;
  logic [7:0]  sh8   = 8'hFF;
  logic [31:0] sh32  = 32'hFFFF_FFFF;

  always @(posedge bus8.latch_out) sh8 <= pat8;
  always @(posedge bus8.pclk_out) if (bus8.busy === 1'b1) sh8 <= {sh8[6:0], 1'b1};
  always @(posedge bus32.latch_out) sh32 <= pat32;
  always @(posedge bus32.pclk_out) if (bus32.busy === 1'b1) sh32 <= {sh32[30:0], 1'b1};

  assign bus8.data_in  = sh8[7];
  assign bus16.data_in = 1'b1;
  assign bus32.data_in = sh32[31];

  // Measurements of the last poll8 run
  int         fv_t, fv_cnt, latch_hi, latch_rise, pclk_pulses, pclk_badw, overlap, busy_hi;
  logic [7:0] frame8;

  // t = 0 is the cycle right after the edge that accepted start
  task automatic poll8(input logic [7:0] pat, input int restart_a, input int restart_b,
                       input int window);
    logic prev_latch;
    int   lowrun;
    pat8 = pat;
    fv_t = -1; fv_cnt = 0; latch_hi = 0; latch_rise = 0;
    pclk_pulses = 0; pclk_badw = 0; overlap = 0; busy_hi = 0; frame8 = '0;
    lowrun = 0;
    @(negedge clk);
    bus8.start = 1'b1;
    prev_latch = bus8.latch_out;
    for (int t = 0; t < window; t++) begin
      @(negedge clk);
      bus8.start = (t == restart_a || t == restart_b);
      if (bus8.latch_out) latch_hi++;
      if (bus8.latch_out && !prev_latch) latch_rise++;
      if (bus8.latch_out && !bus8.pclk_out) overlap++;
      if (bus8.busy) busy_hi++;
      if (!bus8.pclk_out) lowrun++;
      else if (lowrun != 0) begin
        pclk_pulses++;
        if (lowrun != 3) pclk_badw++;
        lowrun = 0;
      end
      if (bus8.frame_valid) begin
        fv_cnt++;
        if (fv_t < 0) begin fv_t = t; frame8 = bus8.frame_out; end
      end
      prev_latch = bus8.latch_out;
    end
    bus8.start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus8.latch_out !== 1'b0) begin errors++; $display("FAIL reset_latch got %b expected 0", bus8.latch_out); end
    checks++; if (bus8.pclk_out !== 1'b1) begin errors++; $display("FAIL reset_pclk got %b expected 1", bus8.pclk_out); end
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus8.busy); end
    checks++; if (bus8.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus8.frame_valid); end
    checks++; if (bus8.frame_out !== 8'hFF) begin errors++; $display("FAIL reset_frame8 got %h expected ff", bus8.frame_out); end
    checks++; if (bus32.frame_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_frame32 got %h expected ffffffff", bus32.frame_out); end
    $display("reset: latch=%b pclk=%b busy=%b frame8=%h", bus8.latch_out, bus8.pclk_out, bus8.busy, bus8.frame_out);
  endtask

  task automatic test_basic_poll();
    poll8(8'hA5, -1, -1, 70);
    // 4 + 3 + 7*2*3 + 1 = 50
    checks++; if (fv_t !== 50) begin errors++; $display("FAIL basic_latency got %0d expected 50", fv_t); end
    checks++; if (frame8 !== 8'hA5) begin errors++; $display("FAIL basic_frame got %h expected a5", frame8); end
    checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL basic_valid_count got %0d expected 1", fv_cnt); end
    checks++; if (latch_hi !== 4) begin errors++; $display("FAIL basic_latch_len got %0d expected 4", latch_hi); end
    checks++; if (latch_rise !== 1) begin errors++; $display("FAIL basic_latch_pulses got %0d expected 1", latch_rise); end
    checks++; if (pclk_pulses !== 7) begin errors++; $display("FAIL basic_pclk_pulses got %0d expected 7", pclk_pulses); end
    checks++; if (pclk_badw !== 0) begin errors++; $display("FAIL basic_pclk_width got %0d bad expected 0", pclk_badw); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL basic_overlap got %0d expected 0", overlap); end
    checks++; if (busy_hi !== 50) begin errors++; $display("FAIL basic_busy_len got %0d expected 50", busy_hi); end
    $display("basic poll: frame=%h latency=%0d latch=%0d pulses=%0d", frame8, fv_t, latch_hi, pclk_pulses);
  endtask

  task automatic test_restart_ignored();
    // t=2 lies in LATCH, t=17 in the second HIGH half
    poll8(8'h3C, 2, 17, 70);
    checks++; if (latch_rise !== 1) begin errors++; $display("FAIL restart_latch_pulses got %0d expected 1", latch_rise); end
    checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL restart_valid_count got %0d expected 1", fv_cnt); end
    checks++; if (pclk_pulses !== 7) begin errors++; $display("FAIL restart_pclk_pulses got %0d expected 7", pclk_pulses); end
    checks++; if (fv_t !== 50) begin errors++; $display("FAIL restart_latency got %0d expected 50", fv_t); end
    checks++; if (frame8 !== 8'h3C) begin errors++; $display("FAIL restart_frame got %h expected 3c", frame8); end
    $display("restart ignored: frame=%h latch pulses=%0d valid=%0d", frame8, latch_rise, fv_cnt);
  endtask

  task automatic test_back_to_back();
    int t1, t2, lr2, nfv;
    logic [7:0] f1, f2;
    logic prev_latch;
    t1 = -1; t2 = -1; lr2 = -1; nfv = 0; f1 = '0; f2 = '0;
    pat8 = 8'h01;
    @(negedge clk);
    bus8.start = 1'b1;
    prev_latch = bus8.latch_out;
    for (int t = 0; t < 120; t++) begin
      @(negedge clk);
      if (bus8.latch_out && !prev_latch && t > 0 && lr2 < 0) begin
        lr2 = t;
        bus8.start = 1'b0;
      end
      prev_latch = bus8.latch_out;
      if (bus8.frame_valid) begin
        nfv++;
        if (t1 < 0) begin t1 = t; f1 = bus8.frame_out; pat8 = 8'h80; end
        else if (t2 < 0) begin t2 = t; f2 = bus8.frame_out; end
      end
    end
    bus8.start = 1'b0;
    checks++; if (t1 !== 50) begin errors++; $display("FAIL b2b_first_latency got %0d expected 50", t1); end
    checks++; if (f1 !== 8'h01) begin errors++; $display("FAIL b2b_first_frame got %h expected 01", f1); end
    // DONE at 49, IDLE at 50 accepts the held start, LATCH visible at 51
    checks++; if (lr2 !== 51) begin errors++; $display("FAIL b2b_second_latch got %0d expected 51", lr2); end
    checks++; if (t2 !== 101) begin errors++; $display("FAIL b2b_second_latency got %0d expected 101", t2); end
    checks++; if (f2 !== 8'h80) begin errors++; $display("FAIL b2b_second_frame got %h expected 80", f2); end
    checks++; if (nfv !== 2) begin errors++; $display("FAIL b2b_valid_count got %0d expected 2", nfv); end
    $display("back to back: frames=%h,%h at %0d,%0d second latch at %0d", f1, f2, t1, t2, lr2);
  endtask

  task automatic test_reset_mid_poll();
    int nfv, nlatch;
    poll8(8'h5A, -1, -1, 60);
    checks++; if (frame8 !== 8'h5A) begin errors++; $display("FAIL midrst_pre_frame got %h expected 5a", frame8); end
    pat8 = 8'hC3;
    @(negedge clk);
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (20) @(negedge clk);
    // t=20: LOW half after three bits have been sampled
    checks++; if (bus8.pclk_out !== 1'b0 || bus8.busy !== 1'b1) begin errors++; $display("FAIL midrst_in_low got pclk=%b busy=%b expected pclk=0 busy=1", bus8.pclk_out, bus8.busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus8.latch_out !== 1'b0) begin errors++; $display("FAIL midrst_latch got %b expected 0", bus8.latch_out); end
    checks++; if (bus8.pclk_out !== 1'b1) begin errors++; $display("FAIL midrst_pclk got %b expected 1", bus8.pclk_out); end
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", bus8.busy); end
    checks++; if (bus8.frame_out !== 8'hFF) begin errors++; $display("FAIL midrst_frame got %h expected ff", bus8.frame_out); end
    rst_n = 1'b1;
    nfv = 0; nlatch = 0;
    for (int t = 0; t < 70; t++) begin
      @(negedge clk);
      if (bus8.frame_valid) nfv++;
      if (bus8.latch_out) nlatch++;
    end
    checks++; if (nfv !== 0) begin errors++; $display("FAIL midrst_no_valid got %0d expected 0", nfv); end
    checks++; if (nlatch !== 0) begin errors++; $display("FAIL midrst_no_latch got %0d expected 0", nlatch); end
    $display("reset mid poll: frame=%h valid pulses after=%0d", bus8.frame_out, nfv);
  endtask

  task automatic test_all_ones16();
    int fv, nfv, nbusy, pulses, lowrun;
    logic [15:0] fr;
    fv = -1; nfv = 0; nbusy = 0; pulses = 0; lowrun = 0; fr = '0;
    @(negedge clk);
    bus16.start = 1'b1;
    for (int t = 0; t < 130; t++) begin
      @(negedge clk);
      bus16.start = 1'b0;
      if (bus16.busy) nbusy++;
      if (!bus16.pclk_out) lowrun++;
      else if (lowrun != 0) begin pulses++; lowrun = 0; end
      if (bus16.frame_valid) begin
        nfv++;
        if (fv < 0) begin fv = t; fr = bus16.frame_out; end
      end
    end
    // 4 + 3 + 15*2*3 + 1 = 98
    checks++; if (fv !== 98) begin errors++; $display("FAIL ones16_latency got %0d expected 98", fv); end
    checks++; if (fr !== 16'hFFFF) begin errors++; $display("FAIL ones16_frame got %h expected ffff", fr); end
    checks++; if (nbusy !== 98) begin errors++; $display("FAIL ones16_busy_len got %0d expected 98", nbusy); end
    checks++; if (pulses !== 15) begin errors++; $display("FAIL ones16_pclk_pulses got %0d expected 15", pulses); end
    checks++; if (nfv !== 1) begin errors++; $display("FAIL ones16_valid_count got %0d expected 1", nfv); end
    $display("all ones 16: frame=%h latency=%0d busy=%0d", fr, fv, nbusy);
  endtask

  task automatic test_wide32();
    int fv, pulses, lowrun;
    logic [31:0] fr;
    fv = -1; pulses = 0; lowrun = 0; fr = '0;
    pat32 = 32'h8000_0001;
    @(negedge clk);
    bus32.start = 1'b1;
    for (int t = 0; t < 220; t++) begin
      @(negedge clk);
      bus32.start = 1'b0;
      if (!bus32.pclk_out) lowrun++;
      else if (lowrun != 0) begin pulses++; lowrun = 0; end
      if (bus32.frame_valid && fv < 0) begin fv = t; fr = bus32.frame_out; end
    end
    // 4 + 3 + 31*2*3 + 1 = 194
    checks++; if (fv !== 194) begin errors++; $display("FAIL wide32_latency got %0d expected 194", fv); end
    checks++; if (fr !== 32'h8000_0001) begin errors++; $display("FAIL wide32_frame got %h expected 80000001", fr); end
    checks++; if (pulses !== 31) begin errors++; $display("FAIL wide32_pclk_pulses got %0d expected 31", pulses); end
    $display("wide 32: frame=%h latency=%0d pulses=%0d", fr, fv, pulses);
  endtask

  initial begin
    rst_n = 1'b0;
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
    bus32.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_poll();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_poll();
    test_all_ones16();
    test_wide32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
